// File: rtl/sync_fifo_pkg.sv
// Shared FIFO types and helpers.
// Default sizes, clog2 and the status bundle reused by the async FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATASIZE = 32;
    localparam int DEF_ADDRSIZE = 5;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one clock, registered read port.
// Ports: clk, rst (read register only), we/waddr/wdata, re/raddr/rdata.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Output register holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, thresholds, sticky errors.
// Ports: clk, rst, wr_en/wdata, rd_en/rdata/rvalid, status flags, count, clr_err.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int AF_LEVEL = (1 << ADDRSIZE) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] C_FULL = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] C_AF = (ADDRSIZE+1)'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] C_AE = (ADDRSIZE+1)'(AE_LEVEL);

    if (!(AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH))
    begin : g_bad_levels
        $error("sync_fifo: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDRSIZE-1:0] wptr;
    logic [ADDRSIZE-1:0] rptr;
    logic [ADDRSIZE:0]   cnt;
    logic [ADDRSIZE:0]   cnt_nxt;
    fifo_status_t        st;
    fifo_status_t        st_nxt;
    logic                push;
    logic                pop;

    // Acceptance uses the registered flags, so a push at full
    // is refused even when a pop frees a slot in the same cycle.
    assign push = wr_en & ~st.full;
    assign pop  = rd_en & ~st.empty;

    always_comb begin
        cnt_nxt = cnt;
        unique case (1'b1)
            push & ~pop: cnt_nxt = cnt + 1'b1;
            pop & ~push: cnt_nxt = cnt - 1'b1;
            default:     cnt_nxt = cnt;
        endcase
    end

    // Flags come from next-count so they line up with count.
    // A fresh error beats clr_err in the same cycle.
    always_comb begin
        st_nxt.full         = (cnt_nxt == C_FULL);
        st_nxt.empty        = (cnt_nxt == '0);
        st_nxt.almost_full  = (cnt_nxt >= C_AF);
        st_nxt.almost_empty = (cnt_nxt <= C_AE);
        st_nxt.overflow     = (wr_en & st.full)
                            | (st.overflow & ~clr_err);
        st_nxt.underflow    = (rd_en & st.empty)
                            | (st.underflow & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            wptr   <= '0;
            rptr   <= '0;
            rvalid <= 1'b0;
            st     <= '{full: 1'b0, empty: 1'b1,
                        almost_full: 1'b0, almost_empty: 1'b1,
                        overflow: 1'b0, underflow: 1'b0};
        end else begin
            cnt    <= cnt_nxt;
            rvalid <= pop;
            st     <= st_nxt;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    sync_fifo_ram #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wptr),
        .wdata (wdata),
        .re    (pop),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign count        = cnt;
    assign full         = st.full;
    assign empty        = st.empty;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;
    assign overflow     = st.overflow;
    assign underflow    = st.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH 4, AF 3, AE 1).
// Queue-based reference model, directed scenarios plus random traffic.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int AFL = 3;
    localparam int AEL = 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    int total;
    int bad;

    // reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_ovf;
    logic          m_udf;

    sync_fifo #(
        .DATASIZE (DW),
        .ADDRSIZE (AW),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {count, full, empty, af, ae, ovf, udf, rvalid, rdata}
    wire [17:0] act = {count, full, empty, almost_full, almost_empty,
                       overflow, underflow, rvalid, rdata};

    function automatic logic [17:0] model_vec();
        int n;
        n = q.size();
        return {3'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL,
                m_ovf, m_udf, m_rvalid, m_rdata};
    endfunction

    task automatic model_reset();
        q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
    endtask

    // Drive one cycle and advance the model from pre-edge state.
    task automatic step(input logic wr, input logic [DW-1:0] d,
                        input logic rd, input logic clr);
        bit mfull;
        bit mempty;
        wr_en   = wr;
        wdata   = d;
        rd_en   = rd;
        clr_err = clr;
        mfull   = (q.size() == DEPTH);
        mempty  = (q.size() == 0);
        @(posedge clk);
        #1;
        m_ovf = (wr && mfull) || (m_ovf && !clr);
        m_udf = (rd && mempty) || (m_udf && !clr);
        m_rvalid = rd && !mempty;
        if (rd && !mempty)
            m_rdata = q.pop_front();
        if (wr && !mfull)
            q.push_back(d);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (act !== model_vec()) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", act, model_vec());
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        async_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL reset_idle got=%h want=%h",
                         act, model_vec());
            end
        end
        total++;
        if ({count, empty, almost_empty, rvalid, rdata}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_values cnt=%0d e=%b ae=%b rv=%b rd=%h",
                     count, empty, almost_empty, rvalid, rdata);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL fill_%0d got=%h want=%h",
                         i, act, model_vec());
            end
        end
        total++;
        if ({count, full, overflow} !== {3'd4, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL fill_overflow cnt=%0d full=%b ovf=%b want 4 1 1",
                     count, full, overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL drain_%0d got=%h want=%h",
                         i, act, model_vec());
            end
        end
        total++;
        if ({underflow, rvalid, rdata} !== {1'b1, 1'b0, 8'hA4}) begin
            bad++;
            $display("FAIL drain_underflow udf=%b rv=%b rd=%h want 1 0 a4",
                     underflow, rvalid, rdata);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h0E, 1'b0, 1'b0);
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            total++;
            if (act !== model_vec() || count !== 3'd2) begin
                bad++;
                $display("FAIL stream_%0d got=%h want=%h",
                         i, act, model_vec());
            end
        end
    endtask

    task automatic test_corners();
        async_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b1, 1'b0);
        total++;
        if (act !== model_vec() || {count, overflow} !== {3'd3, 1'b1}) begin
            bad++;
            $display("FAIL both_at_full got=%h want=%h", act, model_vec());
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'hDD, 1'b1, 1'b0);
        total++;
        if (act !== model_vec() || {count, underflow} !== {3'd1, 1'b1}) begin
            bad++;
            $display("FAIL both_at_empty got=%h want=%h", act, model_vec());
        end
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        total++;
        if (act !== model_vec() || {overflow, underflow} !== 2'b10) begin
            bad++;
            $display("FAIL clr_with_err got=%h want=%h", act, model_vec());
        end
        step(1'b0, '0, 1'b0, 1'b1);
        total++;
        if (act !== model_vec() || {overflow, underflow} !== 2'b00) begin
            bad++;
            $display("FAIL clr_alone got=%h want=%h", act, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        async_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h53, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (act !== model_vec() || rdata !== 8'h61) begin
            bad++;
            $display("FAIL post_reset got=%h want=%h", act, model_vec());
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            if (act !== model_vec()) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_%0d got=%h want=%h",
                             i, act, model_vec());
            end
        end
        total++;
        if (errs !== 0)
            bad++;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wdata   = '0;
        model_reset();
        #12;
        rst = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_corners();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
